// File: rtl/reg_file_wb_pkg.sv
// Shared definitions for the register file / write-back block.
// Holds the one-hot phase bit positions, the write-size encodings, the stack
// pointer location and reset value, and a one-hot test used for phase checking.
package reg_file_wb_pkg;

  // CPU phase bit positions inside the one-hot phase vector
  localparam int PH_F = 0;
  localparam int PH_R = 1;
  localparam int PH_X = 2;
  localparam int PH_M = 3;
  localparam int PH_W = 4;

  localparam int NUM_REGS = 8;

  // Stack pointer register and its reset value
  localparam int          SP_IDX = 4;
  localparam logic [31:0] SP_RST = 32'h0000_FFFC;

  // Write enable / size encodings
  typedef enum logic [1:0] {
    WE_NONE = 2'd0,
    WE_W32  = 2'd1,
    WE_W16  = 2'd2,
    WE_W8   = 2'd3
  } we_e;

  // True when exactly one bit of the phase vector is set
  function automatic logic is_onehot5(input logic [4:0] v);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < 5; i++) begin
      cnt = cnt + {2'b00, v[i]};
    end
    return (cnt == 3'd1);
  endfunction

endpackage

// File: rtl/wb_merge.sv
// Combinational write-size merge.
// Ports:
//   old_val - current register contents
//   new_val - incoming write data
//   size    - write size (none / 32 / low 16 / low 8)
//   merged  - value to store: new bits in the written field, old bits elsewhere
module wb_merge
  import reg_file_wb_pkg::*;
(
  input  logic [31:0] old_val,
  input  logic [31:0] new_val,
  input  logic [1:0]  size,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_val;
    case (size)
      WE_W32:  merged = new_val;
      WE_W16:  merged = {old_val[31:16], new_val[15:0]};
      WE_W8:   merged = {old_val[31:8], new_val[7:0]};
      default: merged = old_val;
    endcase
  end

endmodule

// File: rtl/reg_file_wb.sv
// 8 x 32-bit register file with registered reads and deferred write-back.
// Reads happen on the r phase, the ALU result is buffered on the m phase and
// committed (with size merge) on the w phase.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   phase       - one-hot CPU phase {w, m, x, r, f}
//   ra1, ra2    - read addresses; rd1, rd2 - registered read data
//   we, wa, dr  - ALU write size, address and data (captured on m phase)
//   perr        - sticky flag: phase vector seen not one-hot
//   wcnt        - number of committed writes, wrapping
module reg_file_wb
  import reg_file_wb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  phase,
  input  logic [2:0]  ra1,
  input  logic [2:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic [1:0]  we,
  input  logic [2:0]  wa,
  input  logic [31:0] dr,
  output logic        perr,
  output logic [15:0] wcnt
);

  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];
  logic [31:0] rd1_q, rd1_d;
  logic [31:0] rd2_q, rd2_d;
  logic [1:0]  pend_we_q, pend_we_d;
  logic [2:0]  pend_wa_q, pend_wa_d;
  logic [31:0] pend_dr_q, pend_dr_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        perr_q, perr_d;
  logic [31:0] merged;
  logic        commit;

  wb_merge u_merge (
    .old_val (regs_q[pend_wa_q]),
    .new_val (pend_dr_q),
    .size    (pend_we_q),
    .merged  (merged)
  );

  assign commit = phase[PH_W] && (pend_we_q != WE_NONE);

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    rd1_d     = rd1_q;
    rd2_d     = rd2_q;
    pend_we_d = pend_we_q;
    pend_wa_d = pend_wa_q;
    pend_dr_d = pend_dr_q;
    wcnt_d    = wcnt_q;
    perr_d    = perr_q | ~is_onehot5(phase);

    // Reads sample regs_q, so a simultaneous commit is not visible to them
    if (phase[PH_R]) begin
      rd1_d = regs_q[ra1];
      rd2_d = regs_q[ra2];
    end

    if (commit) begin
      regs_d[pend_wa_q] = merged;
      wcnt_d            = wcnt_q + 16'd1;
      pend_we_d         = WE_NONE;
    end

    // A capture on the same edge as a commit refills the buffer after the
    // old entry has been retired, so the new entry wins over the clear.
    if (phase[PH_M]) begin
      pend_we_d = we;
      pend_wa_d = wa;
      pend_dr_d = dr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_RST : 32'h0;
      end
      rd1_q     <= 32'h0;
      rd2_q     <= 32'h0;
      pend_we_q <= WE_NONE;
      pend_wa_q <= 3'd0;
      pend_dr_q <= 32'h0;
      wcnt_q    <= 16'h0;
      perr_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      rd1_q     <= rd1_d;
      rd2_q     <= rd2_d;
      pend_we_q <= pend_we_d;
      pend_wa_q <= pend_wa_d;
      pend_dr_q <= pend_dr_d;
      wcnt_q    <= wcnt_d;
      perr_q    <= perr_d;
    end
  end

  assign rd1  = rd1_q;
  assign rd2  = rd2_q;
  assign perr = perr_q;
  assign wcnt = wcnt_q;

endmodule
